// File: rtl/weight_sparse_pingpong_pkg.sv
// Shared constants for the sparse-weight ping-pong buffer: load FSM
// encodings and a width helper for index ports.
package weight_sparse_pingpong_pkg;

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_DATA = 2'd1;
  localparam logic [1:0] L_FULL = 2'd2;

  // Index width that never collapses to zero bits for tiny vectors.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_sparse_pingpong_kth_set_bit.sv
// Finds the position of the k-th (0-based) set bit of a vector, scanning
// from bit 0 upward. found_o is low when the vector holds k or fewer ones.
module kth_set_bit #(
  parameter int W  = 3,
  parameter int KW = $clog2(W + 1),
  parameter int PW = (W <= 2) ? 1 : $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  input  logic [KW-1:0] k_i,
  output logic [PW-1:0] pos_o,
  output logic          found_o
);

  logic [KW-1:0] cnt;

  // Running count of ones below bit i; first match on the k-th one wins.
  always_comb begin
    cnt     = '0;
    pos_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) begin
        if (!found_o && (cnt == k_i)) begin
          pos_o   = PW'(i);
          found_o = 1'b1;
        end
        cnt = cnt + KW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_sparse_pingpong.sv
// Double-buffered sparse KxK weight buffer. The shadow bank is filled from a
// nonzero map plus a packed stream of nonzero weights; a consumer start swaps
// it into the active bank, which is presented densely and as a serial walk
// over the nonzero columns of each row.
module weight_sparse_pingpong
  import weight_sparse_pingpong_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_WIDTH = 3,
  localparam int K     = KERNEL_WIDTH,
  localparam int N     = K * K,
  localparam int DW    = DATA_WIDTH,
  localparam int IDX_W = idx_width(K),
  localparam int CNT_W = $clog2(K + 1),
  localparam int NZ_W  = $clog2(N + 1),
  localparam int POS_W = idx_width(N)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              mode_i,
  input  logic              wr_flag_valid_i,
  output logic              wr_flag_ready_o,
  input  logic [N-1:0]      wr_flag_i,
  input  logic              wr_wei_valid_i,
  output logic              wr_wei_ready_o,
  input  logic [DW-1:0]     wr_wei_i,
  input  logic              start_i,
  input  logic              row_cal_done_i,
  input  logic              col_step_i,
  output logic              en_o,
  output logic              kernel_valid_o,
  output logic [IDX_W-1:0]  wei_row_index_o,
  output logic [CNT_W-1:0]  row_val_num_o,
  output logic [IDX_W-1:0]  wei_index_o,
  output logic [DW-1:0]     wei_serial_out_o,
  output logic              wei_serial_valid_o,
  output logic              row_last_o,
  output logic [DW*N-1:0]   wei_parallel_out_o
);

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     sh_flags_q;
  logic [DW*N-1:0]  sh_dense_q;
  logic [NZ_W-1:0]  need_q, wcnt_q, flag_pop;
  logic [N-1:0]     act_flags_q;
  logic [DW*N-1:0]  act_dense_q;
  logic             kv_q, en_q, pend_q, pend_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;

  logic             flag_hs, wei_hs, swap, ser_en, row_last_raw;
  logic [POS_W-1:0] slot, sel;
  logic             slot_found, col_found;
  logic [K-1:0]     row_flags;
  logic [CNT_W-1:0] row_cnt;
  logic [IDX_W-1:0] col_pos;

  assign flag_hs = wr_flag_valid_i && (state_q == L_IDLE);
  assign wei_hs  = wr_wei_valid_i && (state_q == L_DATA);
  // A pending start waits until the shadow bank is complete.
  assign swap    = (start_i || pend_q) && (state_q == L_FULL);
  assign pend_d  = swap ? 1'b0 : (pend_q || start_i);

  // Number of weights the incoming flag word announces.
  always_comb begin
    flag_pop = '0;
    for (int i = 0; i < N; i++) flag_pop = flag_pop + NZ_W'(wr_flag_i[i]);
  end

  // Write slot: weights arrive in raster order, so beat n lands on the n-th set flag.
  kth_set_bit #(.W(N), .KW(NZ_W), .PW(POS_W)) u_slot (
    .vec_i   (sh_flags_q),
    .k_i     (wcnt_q),
    .pos_o   (slot),
    .found_o (slot_found)
  );

  // Load FSM next state for the shadow bank.
  always_comb begin
    state_d = state_q;
    case (state_q)
      L_IDLE: if (flag_hs) state_d = (flag_pop == '0) ? L_FULL : L_DATA;
      L_DATA: if (wei_hs && ((wcnt_q + NZ_W'(1)) == need_q)) state_d = L_FULL;
      L_FULL: if (swap) state_d = L_IDLE;
      default: state_d = L_IDLE;
    endcase
  end

  // Shadow bank fill.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= L_IDLE;
      sh_flags_q <= '0;
      sh_dense_q <= '0;
      need_q     <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (flag_hs) begin
        sh_flags_q <= wr_flag_i;
        sh_dense_q <= '0;
        need_q     <= flag_pop;
        wcnt_q     <= '0;
      end else if (wei_hs) begin
        if (slot_found) sh_dense_q[slot*DW +: DW] <= wr_wei_i;
        wcnt_q <= wcnt_q + NZ_W'(1);
      end
    end
  end

  // Serial row view of the active bank.
  assign row_flags = act_flags_q[row_q*K +: K];

  // Nonzero count of the current row.
  always_comb begin
    row_cnt = '0;
    for (int i = 0; i < K; i++) row_cnt = row_cnt + CNT_W'(row_flags[i]);
  end

  kth_set_bit #(.W(K), .KW(CNT_W), .PW(IDX_W)) u_col (
    .vec_i   (row_flags),
    .k_i     (col_q),
    .pos_o   (col_pos),
    .found_o (col_found)
  );

  assign ser_en       = mode_i && kv_q;
  assign row_last_raw = (row_cnt == '0) || (col_q == (row_cnt - CNT_W'(1)));
  assign sel          = POS_W'(int'(row_q) * K + int'(col_pos));

  // Serial pointer update; swap and dense mode both park the walk at (0,0).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (swap || !mode_i) begin
      row_d = '0;
      col_d = '0;
    end else if (kv_q) begin
      if (row_cal_done_i) begin
        row_d = (row_q == IDX_W'(K - 1)) ? '0 : row_q + IDX_W'(1);
        col_d = '0;
      end else if (col_step_i) begin
        col_d = row_last_raw ? '0 : col_q + CNT_W'(1);
      end
    end
  end

  // Active bank, swap bookkeeping and walk pointers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      act_flags_q <= '0;
      act_dense_q <= '0;
      kv_q        <= 1'b0;
      en_q        <= 1'b0;
      pend_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      en_q   <= swap;
      pend_q <= pend_d;
      row_q  <= row_d;
      col_q  <= col_d;
      if (swap) begin
        act_flags_q <= sh_flags_q;
        act_dense_q <= sh_dense_q;
        kv_q        <= 1'b1;
      end
    end
  end

  assign wr_flag_ready_o    = (state_q == L_IDLE);
  assign wr_wei_ready_o     = (state_q == L_DATA);
  assign en_o               = en_q;
  assign kernel_valid_o     = kv_q;
  assign wei_parallel_out_o = act_dense_q;
  assign wei_row_index_o    = ser_en ? row_q : '0;
  assign row_val_num_o      = ser_en ? row_cnt : '0;
  assign wei_index_o        = (ser_en && col_found) ? col_pos : '0;
  assign wei_serial_out_o   = (ser_en && col_found) ? act_dense_q[sel*DW +: DW] : '0;
  assign wei_serial_valid_o = ser_en && (row_cnt != '0);
  assign row_last_o         = ser_en && row_last_raw;

endmodule

// File: tb/tb_weight_sparse_pingpong.sv
// Scoreboard bench for weight_sparse_pingpong (K=3, DW=8).
module tb_weight_sparse_pingpong;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        wr_flag_valid;
  logic        wr_flag_ready;
  logic [8:0]  wr_flag;
  logic        wr_wei_valid;
  logic        wr_wei_ready;
  logic [7:0]  wr_wei;
  logic        start;
  logic        row_cal_done;
  logic        col_step;
  logic        en;
  logic        kernel_valid;
  logic [1:0]  wei_row_index;
  logic [1:0]  row_val_num;
  logic [1:0]  wei_index;
  logic [7:0]  wei_serial_out;
  logic        wei_serial_valid;
  logic        row_last;
  logic [71:0] wei_parallel_out;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] num;
    logic [1:0] idx;
    logic [7:0] dat;
    logic       vld;
    logic       last;
  } ser_t;

  logic [71:0] par_q[$];
  ser_t        ser_q[$];
  logic        ser_chk = 1'b0;

  weight_sparse_pingpong #(.DATA_WIDTH(8), .KERNEL_WIDTH(3)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .mode_i             (mode),
    .wr_flag_valid_i    (wr_flag_valid),
    .wr_flag_ready_o    (wr_flag_ready),
    .wr_flag_i          (wr_flag),
    .wr_wei_valid_i     (wr_wei_valid),
    .wr_wei_ready_o     (wr_wei_ready),
    .wr_wei_i           (wr_wei),
    .start_i            (start),
    .row_cal_done_i     (row_cal_done),
    .col_step_i         (col_step),
    .en_o               (en),
    .kernel_valid_o     (kernel_valid),
    .wei_row_index_o    (wei_row_index),
    .row_val_num_o      (row_val_num),
    .wei_index_o        (wei_index),
    .wei_serial_out_o   (wei_serial_out),
    .wei_serial_valid_o (wei_serial_valid),
    .row_last_o         (row_last),
    .wei_parallel_out_o (wei_parallel_out)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] mk4(input int s0, input int v0, input int s1, input int v1,
                                      input int s2, input int v2, input int s3, input int v3);
    logic [71:0] r;
    r = '0;
    r[s0*8 +: 8] = 8'(v0);
    r[s1*8 +: 8] = 8'(v1);
    r[s2*8 +: 8] = 8'(v2);
    r[s3*8 +: 8] = 8'(v3);
    return r;
  endfunction

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timed out, got no response expected one", nm);
  endtask

  // Monitor: dense kernel checked whenever en pulses, serial tuple when strobed.
  always @(negedge clk) begin
    if (!reset) begin
      if (en) begin
        tests_run++;
        if (par_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_en: got en=1 expected no swap");
        end else begin
          logic [71:0] e;
          e = par_q.pop_front();
          if (wei_parallel_out !== e || kernel_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL parallel: got %0h kv=%0b expected %0h kv=1", wei_parallel_out, kernel_valid, e);
          end
        end
      end
      if (ser_chk) begin
        ser_t a, e;
        a = '{wei_row_index, row_val_num, wei_index, wei_serial_out, wei_serial_valid, row_last};
        tests_run++;
        if (ser_q.size() == 0) begin
          tests_failed++;
          $display("FAIL serial_empty: got strobe expected queued value");
        end else begin
          e = ser_q.pop_front();
          if (a !== e) begin
            tests_failed++;
            $display("FAIL serial: got r=%0d n=%0d i=%0d d=%0d v=%0b l=%0b expected r=%0d n=%0d i=%0d d=%0d v=%0b l=%0b",
                     a.row, a.num, a.idx, a.dat, a.vld, a.last, e.row, e.num, e.idx, e.dat, e.vld, e.last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flag(input logic [8:0] f);
    bit done = 1'b0;
    wr_flag = f;
    wr_flag_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (wr_flag_ready) done = 1'b1;
      tick();
    end
    wr_flag_valid = 1'b0;
    if (!done) timeout("flag_handshake");
  endtask

  task automatic send_wei(input int w);
    bit done = 1'b0;
    wr_wei = 8'(w);
    wr_wei_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (wr_wei_ready) done = 1'b1;
      tick();
    end
    wr_wei_valid = 1'b0;
    if (!done) timeout("wei_handshake");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_en();
    bit seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (en) seen = 1'b1;
      else tick();
    end
    if (!seen) timeout("wait_en");
  endtask

  task automatic ser_expect(input int r, input int n, input int i, input int d, input bit v, input bit l);
    ser_t e;
    e = '{2'(r), 2'(n), 2'(i), 8'(d), v, l};
    ser_q.push_back(e);
    ser_chk = 1'b1;
    @(negedge clk);
    #1;
    ser_chk = 1'b0;
    tick();
  endtask

  task automatic step(input bit rcd, input bit cs);
    row_cal_done = rcd;
    col_step = cs;
    tick();
    row_cal_done = 1'b0;
    col_step = 1'b0;
  endtask

  logic [71:0] k_a, k_b, k_c;

  initial begin
    reset = 1'b1; mode = 1'b0; wr_flag_valid = 1'b0; wr_flag = '0;
    wr_wei_valid = 1'b0; wr_wei = '0; start = 1'b0; row_cal_done = 1'b0; col_step = 1'b0;
    k_a = mk4(0, 11, 1, 22, 4, 33, 8, 44);
    k_b = mk4(0, 5, 2, 6, 7, 7, 8, 8);
    k_c = mk4(0, 1, 1, 2, 4, 3, 8, 4);
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 72'(en), 72'd0);
    check("rst_kv", 72'(kernel_valid), 72'd0);
    check("rst_flag_ready", 72'(wr_flag_ready), 72'd1);
    check("rst_wei_ready", 72'(wr_wei_ready), 72'd0);
    check("rst_parallel", wei_parallel_out, 72'd0);
    reset = 1'b0;
    tick();

    // Dense load and swap.
    send_flag(9'b100_010_011);
    par_q.push_back(k_a);
    send_wei(11); send_wei(22); send_wei(33); send_wei(44);
    check("full_flag_ready", 72'(wr_flag_ready), 72'd0);
    check("full_wei_ready", 72'(wr_wei_ready), 72'd0);
    pulse_start();
    wait_en();
    ser_expect(0, 0, 0, 0, 1'b0, 1'b0);

    // Serial walk of the same kernel.
    mode = 1'b1;
    ser_expect(0, 2, 0, 11, 1'b1, 1'b0);
    step(1'b0, 1'b1); ser_expect(0, 2, 1, 22, 1'b1, 1'b1);
    step(1'b0, 1'b1); ser_expect(0, 2, 0, 11, 1'b1, 1'b0);
    step(1'b1, 1'b0); ser_expect(1, 1, 1, 33, 1'b1, 1'b1);
    step(1'b0, 1'b1); ser_expect(1, 1, 1, 33, 1'b1, 1'b1);
    step(1'b1, 1'b1); ser_expect(2, 1, 2, 44, 1'b1, 1'b1);
    step(1'b1, 1'b0); ser_expect(0, 2, 0, 11, 1'b1, 1'b0);
    mode = 1'b0;
    tick();

    // Ping-pong: load B while A is active, start arrives early (twice).
    send_flag(9'b110_000_101);
    par_q.push_back(k_b);
    send_wei(5); send_wei(6);
    pulse_start();
    pulse_start();
    check("pend_no_en", 72'(en), 72'd0);
    check("a_held_mid", wei_parallel_out, k_a);
    send_wei(7); send_wei(8);
    check("b_full_flag_ready", 72'(wr_flag_ready), 72'd0);
    check("a_held_full", wei_parallel_out, k_a);
    wait_en();
    tick();

    // Empty kernel: no weight phase, no swap without a fresh start.
    send_flag(9'b000_000_000);
    check("empty_wei_ready", 72'(wr_wei_ready), 72'd0);
    check("empty_flag_ready", 72'(wr_flag_ready), 72'd0);
    repeat (3) tick();
    check("no_stale_pend", wei_parallel_out, k_b);
    par_q.push_back(72'd0);
    pulse_start();
    wait_en();
    mode = 1'b1;
    ser_expect(0, 0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0); ser_expect(1, 0, 0, 0, 1'b0, 1'b1);
    mode = 1'b0;
    tick();

    // Reset in the middle of a load, then a clean reload.
    send_flag(9'b100_010_011);
    send_wei(11); send_wei(22);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_kv", 72'(kernel_valid), 72'd0);
    check("mid_rst_flag_ready", 72'(wr_flag_ready), 72'd1);
    check("mid_rst_wei_ready", 72'(wr_wei_ready), 72'd0);
    check("mid_rst_parallel", wei_parallel_out, 72'd0);
    tick();
    reset = 1'b0;
    tick();
    send_flag(9'b100_010_011);
    par_q.push_back(k_c);
    send_wei(1); send_wei(2); send_wei(3); send_wei(4);
    pulse_start();
    wait_en();
    repeat (3) tick();

    check("par_queue_drained", 72'(par_q.size()), 72'd0);
    check("ser_queue_drained", 72'(ser_q.size()), 72'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

endmodule
